// File: rtl/key_count_seg_display_pkg.sv
// ============================================================================
// key_count_seg_display_pkg : shared 7-segment display constants and types
// Revision: 1.0
// ============================================================================
`default_nettype none

package key_count_seg_display_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  // Active-low segment patterns, bit order g..a
  localparam logic [6:0] SEG_0     = 7'h40;
  localparam logic [6:0] SEG_1     = 7'h79;
  localparam logic [6:0] SEG_2     = 7'h24;
  localparam logic [6:0] SEG_3     = 7'h30;
  localparam logic [6:0] SEG_4     = 7'h19;
  localparam logic [6:0] SEG_5     = 7'h12;
  localparam logic [6:0] SEG_6     = 7'h02;
  localparam logic [6:0] SEG_7     = 7'h78;
  localparam logic [6:0] SEG_8     = 7'h00;
  localparam logic [6:0] SEG_9     = 7'h10;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

`default_nettype wire

// File: rtl/seg_decoder.sv
// ============================================================================
// seg_decoder : BCD nibble to active-low 7-segment pattern, with blanking
// Revision: 1.0
// ============================================================================
`default_nettype none

module seg_decoder
  import key_count_seg_display_pkg::*;
(
  input  bcd_digit_t i_bcd,
  input  logic       i_blank,
  output logic [6:0] o_seg
);

  always_comb begin
    o_seg = SEG_BLANK;
    if (!i_blank) begin
      case (i_bcd)
        4'd0:    o_seg = SEG_0;
        4'd1:    o_seg = SEG_1;
        4'd2:    o_seg = SEG_2;
        4'd3:    o_seg = SEG_3;
        4'd4:    o_seg = SEG_4;
        4'd5:    o_seg = SEG_5;
        4'd6:    o_seg = SEG_6;
        4'd7:    o_seg = SEG_7;
        4'd8:    o_seg = SEG_8;
        4'd9:    o_seg = SEG_9;
        default: o_seg = SEG_BLANK;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/key_count_seg_display.sv
// ============================================================================
// key_count_seg_display : 4-digit BCD press counter with multiplexed
//                         common-anode 7-segment display scanner
// Revision: 1.0
// ============================================================================
`default_nettype none

module key_count_seg_display
  import key_count_seg_display_pkg::*;
#(
  parameter int CLK_HZ        = 50_000_000,
  parameter int SCAN_HZ       = 1000,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          press_pulse,
  input  logic                          clr,
  output logic [NUM_DIGITS*DIGIT_W-1:0] count_bcd,
  output logic                          overflow,
  output logic [7:0]                    seg,
  output logic [3:0]                    sel
);

  localparam int SCAN_DIV = CLK_HZ / SCAN_HZ - 1;
  localparam int SCAN_W   = (SCAN_DIV > 0) ? $clog2(SCAN_DIV + 1) : 1;
  localparam logic [SCAN_W-1:0] c_scan_div = SCAN_W'(SCAN_DIV);

  logic                          r_press_d;
  bcd_digit_t [NUM_DIGITS-1:0]   r_count;
  logic                          r_overflow;
  logic [SCAN_W-1:0]             r_scan;
  logic [1:0]                    r_idx;
  logic [7:0]                    r_seg;
  logic [3:0]                    r_sel;

  logic                          w_inc;
  logic                          w_carry;
  bcd_digit_t [NUM_DIGITS-1:0]   w_count_inc;
  logic [NUM_DIGITS-1:0]         w_hi_zero;
  logic                          w_blank;
  logic [6:0]                    w_seg7;

  assign w_inc = press_pulse & ~r_press_d;

  // Ripple BCD increment; w_carry left set means 9999 wrapped to 0000
  always_comb begin
    w_carry     = 1'b1;
    w_count_inc = r_count;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (w_carry) begin
        if (r_count[k] == 4'd9) begin
          w_count_inc[k] = 4'd0;
        end else begin
          w_count_inc[k] = r_count[k] + 4'd1;
          w_carry        = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_press_d  <= 1'b0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      r_press_d <= press_pulse;
      if (clr) begin
        r_count    <= '0;
        r_overflow <= 1'b0;
      end else if (w_inc) begin
        r_count <= w_count_inc;
        if (w_carry) r_overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_scan <= '0;
      r_idx  <= 2'd0;
    end else if (r_scan == c_scan_div) begin
      r_scan <= '0;
      r_idx  <= r_idx + 2'd1;
    end else begin
      r_scan <= r_scan + 1'b1;
    end
  end

  // w_hi_zero[k]: digit k and every digit above it are zero
  always_comb begin
    w_hi_zero = '1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      for (int j = k; j < NUM_DIGITS; j++) begin
        if (r_count[j] != 4'd0) w_hi_zero[k] = 1'b0;
      end
    end
  end

  assign w_blank = BLANK_LEADING && (r_idx != 2'd0) && w_hi_zero[r_idx];

  seg_decoder u_seg_decoder (
    .i_bcd   (r_count[r_idx]),
    .i_blank (w_blank),
    .o_seg   (w_seg7)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_seg <= 8'hFF;
      r_sel <= 4'hF;
    end else begin
      r_seg <= {~((r_idx == 2'd3) && r_overflow), w_seg7};
      r_sel <= ~(4'b0001 << r_idx);
    end
  end

  assign count_bcd = r_count;
  assign overflow  = r_overflow;
  assign seg       = r_seg;
  assign sel       = r_sel;

endmodule

`default_nettype wire

// File: tb/tb_key_count_seg_display.sv
// ============================================================================
// tb_key_count_seg_display : scoreboard bench for the press counter/display
// Revision: 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_key_count_seg_display;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        press_pulse = 1'b0;
  logic        clr = 1'b0;
  logic [15:0] count_bcd;
  logic        overflow;
  logic [7:0]  seg;
  logic [3:0]  sel;

  int tests = 0;
  int fails = 0;

  logic [16:0] cnt_q[$];
  logic [11:0] disp_q[$];
  logic [16:0] prev_cnt = '0;
  int          model_n = 0;
  logic        model_ovf = 1'b0;

  key_count_seg_display #(
    .CLK_HZ        (4000),
    .SCAN_HZ       (1000),
    .BLANK_LEADING (1'b1)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .press_pulse (press_pulse),
    .clr         (clr),
    .count_bcd   (count_bcd),
    .overflow    (overflow),
    .seg         (seg),
    .sel         (sel)
  );

  always #5 clk = ~clk;

  function automatic logic [15:0] to_bcd(input int n);
    return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: count/overflow changes and display frames are matched against the queues
  always @(negedge clk) begin
    if (rst_n) begin
      if ({overflow, count_bcd} !== prev_cnt) begin
        if (cnt_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected count change: got %0h after %0h", {overflow, count_bcd}, prev_cnt);
        end else begin
          check("count/overflow", {15'd0, overflow, count_bcd}, {15'd0, cnt_q.pop_front()});
        end
      end
      if (disp_q.size() != 0 && sel == disp_q[0][11:8])
        check("display sel/seg", {20'd0, sel, seg}, {20'd0, disp_q.pop_front()});
    end
    prev_cnt = {overflow, count_bcd};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_inc();
    model_n++;
    if (model_n == 10000) begin
      model_n   = 0;
      model_ovf = 1'b1;
    end
    cnt_q.push_back({model_ovf, to_bcd(model_n)});
  endtask

  task automatic press(input int hold);
    press_pulse = 1'b1;
    model_inc();
    repeat (hold) tick();
    press_pulse = 1'b0;
    tick();
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((cnt_q.size() != 0 || disp_q.size() != 0) && n < 60) begin
      tick();
      n++;
    end
    if (cnt_q.size() != 0 || disp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain timeout: %0d count and %0d display expectations pending",
               cnt_q.size(), disp_q.size());
      cnt_q.delete();
      disp_q.delete();
    end
  endtask

  task automatic expect_frame(input logic [7:0] s0, input logic [7:0] s1,
                              input logic [7:0] s2, input logic [7:0] s3);
    wait_drain();
    tick();
    tick();
    disp_q.push_back({4'hE, s0});
    disp_q.push_back({4'hD, s1});
    disp_q.push_back({4'hB, s2});
    disp_q.push_back({4'h7, s3});
    wait_drain();
  endtask

  initial begin
    logic [3:0] seq [4];
    int n;
    seq = '{4'hE, 4'hD, 4'hB, 4'h7};

    // Reset
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset count", {16'd0, count_bcd}, 32'h0);
    check("reset overflow", {31'd0, overflow}, 32'h0);
    check("reset seg", {24'd0, seg}, 32'hFF);
    check("reset sel", {28'd0, sel}, 32'hF);
    rst_n = 1'b1;
    @(negedge clk);
    check("first sel after reset", {28'd0, sel}, 32'hE);
    check("first seg after reset", {24'd0, seg}, 32'hC0);
    tick();

    // Single press held 10 cycles
    press_pulse = 1'b1;
    model_inc();
    tick();
    check("press latency", {16'd0, count_bcd}, 32'h0001);
    repeat (9) tick();
    press_pulse = 1'b0;
    tick();
    expect_frame(8'hF9, 8'hFF, 8'hFF, 8'hFF);

    // BCD carry 0009 -> 0010
    repeat (8) press(1);
    wait_drain();
    press(1);
    expect_frame(8'hC0, 8'hF9, 8'hFF, 8'hFF);

    // Wrap 9999 -> 0000 with overflow
    while (model_n != 9999) press(1);
    wait_drain();
    press(1);
    expect_frame(8'hC0, 8'hFF, 8'hFF, 8'h7F);

    // clr with simultaneous press at 0042, overflow set
    repeat (42) press(1);
    expect_frame(8'hA4, 8'h99, 8'hFF, 8'h7F);
    clr         = 1'b1;
    press_pulse = 1'b1;
    model_n     = 0;
    model_ovf   = 1'b0;
    cnt_q.push_back({1'b0, 16'h0000});
    tick();
    check("clr count", {16'd0, count_bcd}, 32'h0);
    check("clr overflow", {31'd0, overflow}, 32'h0);
    clr         = 1'b0;
    press_pulse = 1'b0;
    tick();
    press(1);
    wait_drain();

    // Reset mid-scan at 0123
    repeat (122) press(1);
    expect_frame(8'hB0, 8'hA4, 8'hF9, 8'hFF);
    n = 0;
    while (sel !== 4'hB && n < 40) begin
      tick();
      n++;
    end
    check("reach digit 2 before reset", {28'd0, sel}, 32'hB);
    rst_n = 1'b0;
    #1;
    check("async reset count", {16'd0, count_bcd}, 32'h0);
    check("async reset overflow", {31'd0, overflow}, 32'h0);
    check("async reset seg", {24'd0, seg}, 32'hFF);
    check("async reset sel", {28'd0, sel}, 32'hF);
    model_n   = 0;
    model_ovf = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      check("post-reset sel sequence", {28'd0, sel}, {28'd0, seq[i / 4]});
      if (i == 0) check("post-reset seg units", {24'd0, seg}, 32'hC0);
      if (i == 4) check("post-reset seg tens blank", {24'd0, seg}, 32'hFF);
    end
    tick();
    press(1);
    wait_drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, %0d tests run", tests);
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire

// File: doc/key_count_seg_display.md
Name: key_count_seg_display

Overview:
Downstream consumer of the key debounce stage. Takes the single-cycle debounced press flag and keeps a 4-digit BCD press count (0000–9999). Drives a 4-digit multiplexed 7-segment display (common-anode, active-low) that shows the count. Replaces ad-hoc combinational counting with a fully clocked counter and display scanner.

Parameters:
CLK_HZ, 50_000_000, system clock frequency in Hz
SCAN_HZ, 1000, digit switch rate in Hz (full frame = SCAN_HZ/4)
BLANK_LEADING, 1, 1 = blank leading zeros on digits 3..1; 0 = show all digits

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous reset, active-low
press_pulse  input  1  debounced key press flag from debounce stage, active-high
clr  input  1  synchronous clear of count and overflow, active-high
count_bcd  output  16  current count, 4 BCD digits, [3:0] = units
overflow  output  1  sticky; set on wrap 9999->0000
seg  output  8  segment drive, active-low; [7] = dp, [6:0] = g..a
sel  output  4  digit select, active-low; sel[0] = units digit

Behaviour:
- Reset: rst_n is asynchronous, active-low; clock is clk. While rst_n=0: count_bcd=16'h0000, overflow=0, seg=8'hFF, sel=4'hF, scan counter=0, digit index=0, press edge register=0.
- Press detection: press_pulse is registered into press_d. inc = press_pulse & ~press_d.
  - A level held high for N cycles counts once.
  - Minimum low time between counted presses: 1 cycle.
- Counter: on inc, count_bcd increments in BCD; the new value is visible at the clock edge after the cycle in which inc is true.
  - Digit carry: 9 -> 0 carries into the next digit. Non-BCD nibbles cannot occur.
  - Wrap: 9999 + 1 -> 0000 and overflow <= 1. overflow stays set until clr or reset.
- clr: count_bcd <= 0 and overflow <= 0 on the next edge. clr has priority over a simultaneous inc (that press is dropped). press_d still updates.
- Scan timer: SCAN_DIV = CLK_HZ/SCAN_HZ - 1. The scan counter counts 0..SCAN_DIV.
  - At SCAN_DIV it returns to 0 and the digit index advances 0->1->2->3->0 (2-bit wrap).
- Display outputs: registered, updated every clock from the current digit index and count_bcd. Latency 1 clk after an index change or count change.
  - sel = ~(4'b0001 << idx).
  - seg[6:0] = decode of count_bcd[idx*4 +: 4].
  - seg[7] (dp) = 0 (lit) only when idx=3 and overflow=1; otherwise 1.
- Leading-zero blanking (BLANK_LEADING=1):
  - Digit k (k=3..1) is blank (seg[6:0]=7'h7F) when it and all higher digits are 0.
  - Digit 0 is never blanked.
  - dp on digit 3 still lights when overflow=1, even if digit 3 is blank.
- Decode table, seg[6:0] active-low: 0=40 1=79 2=24 3=30 4=19 5=12 6=02 7=78 8=00 9=10.
- Reset asserted mid-scan or mid-count: everything returns to reset values immediately. After release, scanning restarts at idx=0 with the counter at 0.
- No combinational path from press_pulse or clr to any output.

Decomposition:
- Shared package (display pkg): 7-seg pattern constants SEG_0..SEG_9 and SEG_BLANK, DIGIT_W=4, NUM_DIGITS=4, and a BCD digit typedef (4-bit).
- Sub-module seg_decoder: combinational, BCD nibble plus blank -> 7-bit active-low pattern. Reused by later display blocks.
- The BCD counter and scanner stay in the top module.

Test Plan (CLK_HZ=4000, SCAN_HZ=1000 -> SCAN_DIV=3, BLANK_LEADING=1):
1. Reset.
   - Stimulus: hold rst_n=0 for 3 clk, release.
   - Required: count_bcd=0000, overflow=0, seg=FF, sel=F during reset. First registered cycle after release: sel=E, seg=C0 (units '0', dp off).
2. Single press, held 10 cycles.
   - Stimulus: press_pulse high for 10 cycles.
   - Required: count_bcd=0001 exactly one clk after the rising edge; no further increments. When idx=0: sel=E, seg=F9. When idx=1..3: seg=FF (blanked).
3. BCD carry.
   - Stimulus: from 0009, one press.
   - Required: count_bcd=0010. idx=1 shows seg=F9; idx=0 shows seg=C0; idx=2 and idx=3 blank.
4. Wrap and overflow.
   - Stimulus: preload to 9999 via 9999 presses, then one more.
   - Required: count_bcd=0000, overflow=1. idx=3: sel=7, seg=7F (blank digit, dp lit). idx=0: seg=C0.
5. clr with simultaneous press.
   - Stimulus: at count 0042 with overflow=1, assert clr and a press edge in the same cycle.
   - Required: next edge count_bcd=0000, overflow=0. A following press gives 0001.
6. Reset mid-scan.
   - Stimulus: assert rst_n=0 at idx=2 with count 0123.
   - Required: outputs return to reset values asynchronously. After release, sel sequence is E, D, B, 7, each held 4 clk.
